// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential digit-serial multiplier controller.
// Holds the FSM state encoding and the digit counter width helper.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit operand still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int digits);
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Start/busy/done handshake and operand/product bus of the sequential multiplier.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input P);

    modport slave  (input  start, input  a, input  b,
                    output busy,  output done, output P);
endinterface

// File: rtl/mult_seq_ctrl_2x2.sv
// Combinational gate-level 2-bit x 2-bit unsigned multiplier.
module mult_2x2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    logic t10;
    logic t01;
    logic t11;
    logic c1;

    assign t10 = x[1] & y[0];
    assign t01 = x[0] & y[1];
    assign t11 = x[1] & y[1];
    assign c1  = t10 & t01;

    assign p[0] = x[0] & y[0];
    assign p[1] = t10 ^ t01;
    assign p[2] = t11 ^ c1;
    assign p[3] = t11 & c1;
endmodule

// File: rtl/mult_seq_ctrl.sv
// WIDTH x WIDTH unsigned multiplier built from one shared 2x2 multiplier,
// stepping through every digit pair and accumulating shifted partial products.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    mult_seq_ctrl_if.slave  bus
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = cnt_width(DIGITS);
    localparam int PW     = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ra_q, ra_d;
    logic [WIDTH-1:0]  rb_q, rb_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CW-1:0]     i_q, i_d;
    logic [CW-1:0]     j_q, j_d;

    logic [1:0]        dig_a;
    logic [1:0]        dig_b;
    logic [3:0]        pp;
    logic [CW:0]       pos;
    logic [PW-1:0]     pp_shift;

    assign dig_a = ra_q[{i_q, 1'b0} +: 2];
    assign dig_b = rb_q[{j_q, 1'b0} +: 2];

    mult_2x2 u_mult (
        .x (dig_a),
        .y (dig_b),
        .p (pp)
    );

    // Digit pair (i,j) carries weight 4^(i+j).
    assign pos      = {1'b0, i_q} + {1'b0, j_q};
    assign pp_shift = PW'(pp) << {pos, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        p_d     = p_q;
        i_d     = i_q;
        j_d     = j_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + pp_shift;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        p_d     = acc_q + pp_shift;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.P    = p_q;
endmodule
